q2_sequencer: RTL and testbench



---
 rtl/q2_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_q2_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_sequencer.sv
// Q2 instruction-state sequencer.
// Steps each instruction through FETCH/DEREF/LOAD/EXEC and the bit-serial
// ALU phase. Also owns run/halt/single-step and the front-panel
// deposit/examine sequence. Every output is a flop decoded from the next
// state, so the control decode downstream sees glitch-free levels.
module q2_sequencer #(
    parameter int ALU_BITS = 12,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic step,
    input  logic dep_req,
    input  logic exam_req,
    input  logic deref,
    input  logic o2,
    input  logic alu_op,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic halted,
    output logic dep,
    output logic incp
);

    typedef enum logic [2:0] {
        ST_HALT,
        ST_FETCH,
        ST_DEREF,
        ST_LOAD,
        ST_EXEC,
        ST_ALU,
        ST_FP_DEP,
        ST_FP_INC
    } state_t;

    localparam logic [CW-1:0] LAST_IT = CW'(ALU_BITS - 1);

    state_t        state, nxt_state, bnd_state;
    logic          phase, nxt_phase;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          step_flag, nxt_step_flag;
    logic          step_q, dep_q, exam_q;
    logic          step_edge, dep_edge, exam_edge;
    logic          nxt_active;

    // Front-panel switches become one-cycle requests against their last value.
    // They are only acted on in HALT, so edges seen elsewhere simply vanish.
    assign step_edge = step & ~step_q;
    assign dep_edge  = dep_req & ~dep_q;
    assign exam_edge = exam_req & ~exam_q;

    // A single-stepped instruction must stop at its boundary even with run=1.
    assign bnd_state = (run && !step_flag) ? ST_FETCH : ST_HALT;

    // Next-state, phase and ALU-iteration logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        nxt_state     = state;
        nxt_phase     = phase;
        nxt_cnt       = cnt;
        nxt_step_flag = step_flag;

        unique case (state)
            ST_HALT: begin
                nxt_phase = 1'b0;
                nxt_cnt   = '0;
                if (dep_edge) begin
                    nxt_state = ST_FP_DEP;
                end else if (exam_edge) begin
                    nxt_state = ST_FP_INC;
                end else if (step_edge) begin
                    nxt_state     = ST_FETCH;
                    nxt_step_flag = 1'b1;
                end else if (run) begin
                    nxt_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                nxt_phase = ~phase;
                if (phase) begin
                    if (deref)    nxt_state = ST_DEREF;
                    else if (!o2) nxt_state = ST_LOAD;
                    else          nxt_state = ST_EXEC;
                end
            end
            ST_DEREF: begin
                nxt_phase = ~phase;
                if (phase) nxt_state = o2 ? ST_EXEC : ST_LOAD;
            end
            ST_LOAD: begin
                nxt_phase = ~phase;
                if (phase) nxt_state = ST_EXEC;
            end
            ST_EXEC: begin
                nxt_phase = ~phase;
                if (phase) begin
                    if (alu_op) begin
                        nxt_state = ST_ALU;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_state     = bnd_state;
                        nxt_step_flag = 1'b0;
                    end
                end
            end
            ST_ALU: begin
                nxt_phase = ~phase;
                if (phase) begin
                    if (cnt == LAST_IT) begin
                        nxt_state     = bnd_state;
                        nxt_step_flag = 1'b0;
                    end else begin
                        nxt_cnt = cnt + CW'(1);
                    end
                end
            end
            ST_FP_DEP: begin
                nxt_phase = 1'b0;
                nxt_state = ST_FP_INC;
            end
            ST_FP_INC: begin
                nxt_phase = 1'b0;
                nxt_state = ST_HALT;
            end
            default: begin
                nxt_phase = 1'b0;
                nxt_state = ST_HALT;
            end
        endcase
    end

    assign nxt_active = (nxt_state == ST_FETCH) || (nxt_state == ST_DEREF) ||
                        (nxt_state == ST_LOAD)  || (nxt_state == ST_EXEC)  ||
                        (nxt_state == ST_ALU);

    // State registers plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every flop samples
        // the pre-edge values no matter how the statements are ordered.
        if (rst) begin
            state     <= ST_HALT;
            phase     <= 1'b0;
            cnt       <= '0;
            step_flag <= 1'b0;
            step_q    <= 1'b0;
            dep_q     <= 1'b0;
            exam_q    <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            ws        <= 1'b0;
            halted    <= 1'b1;
            dep       <= 1'b0;
            incp      <= 1'b0;
        end else begin
            state     <= nxt_state;
            phase     <= nxt_phase;
            cnt       <= nxt_cnt;
            step_flag <= nxt_step_flag;
            step_q    <= step;
            dep_q     <= dep_req;
            exam_q    <= exam_req;
            s0        <= (nxt_state == ST_DEREF) || (nxt_state == ST_EXEC);
            s1        <= (nxt_state == ST_LOAD)  || (nxt_state == ST_EXEC);
            s2        <= (nxt_state == ST_ALU);
            s3        <= (nxt_state == ST_ALU) && (nxt_cnt == LAST_IT);
            ws        <= nxt_active && nxt_phase;
            halted    <= (nxt_state == ST_HALT);
            dep       <= (nxt_state == ST_FP_DEP);
            incp      <= (nxt_state == ST_FP_INC);
        end
    end

endmodule

// File: tb/tb_q2_sequencer.sv
// Bench for q2_sequencer. Two instances (ALU_BITS=4 and 12) share one set of
// stimulus. A beat-stream model predicts their outputs cycle by cycle, and
// directed checks pin the key scenarios with literal values.
module tb_q2_sequencer;

    logic clk, rst, run, step, dep_req, exam_req, deref, o2, alu_op;
    logic s0_4, s1_4, s2_4, s3_4, ws_4, halted_4, dep_4, incp_4;
    logic s0_c, s1_c, s2_c, s3_c, ws_c, halted_c, dep_c, incp_c;
    logic [7:0] o4, o12;

    // Packed as {incp, dep, halted, ws, s3, s2, s1, s0}.
    assign o4  = {incp_4, dep_4, halted_4, ws_4, s3_4, s2_4, s1_4, s0_4};
    assign o12 = {incp_c, dep_c, halted_c, ws_c, s3_c, s2_c, s1_c, s0_c};

    q2_sequencer #(.ALU_BITS(4), .CW(2)) u_dut4 (
        .clk(clk), .rst(rst), .run(run), .step(step), .dep_req(dep_req),
        .exam_req(exam_req), .deref(deref), .o2(o2), .alu_op(alu_op),
        .s0(s0_4), .s1(s1_4), .s2(s2_4), .s3(s3_4), .ws(ws_4),
        .halted(halted_4), .dep(dep_4), .incp(incp_4)
    );

    q2_sequencer #(.ALU_BITS(12), .CW(4)) u_dut12 (
        .clk(clk), .rst(rst), .run(run), .step(step), .dep_req(dep_req),
        .exam_req(exam_req), .deref(deref), .o2(o2), .alu_op(alu_op),
        .s0(s0_c), .s1(s1_c), .s2(s2_c), .s3(s3_c), .ws(ws_c),
        .halted(halted_c), .dep(dep_c), .incp(incp_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Each state is a list of output beats. The last beat of a state carries
    // the decision that picks what follows.
    typedef enum int {T_NONE, T_HALT, T_DEP, T_INC, T_FETCH, T_DEREF, T_LOAD, T_EXEC, T_BOUND} tag_t;
    typedef struct { logic [7:0] outs; tag_t tag; } beat_t;

    localparam logic [7:0] O_HALT = 8'b0010_0000;
    localparam logic [7:0] O_DEP  = 8'b0100_0000;
    localparam logic [7:0] O_INC  = 8'b1000_0000;

    beat_t bbuf [2][32];
    int    bi [2];
    beat_t cur [2];
    bit    pend [2];
    int    nbits [2] = '{4, 12};
    bit    model_valid = 1'b0;
    logic  p_step, p_dep, p_exam;

    task automatic start_seg(input int k, input int kind);
        logic [1:0] code;
        tag_t t;
        if (kind < 4) begin
            code = kind[1:0];
            case (kind)
                0:       t = T_FETCH;
                1:       t = T_DEREF;
                2:       t = T_LOAD;
                default: t = T_EXEC;
            endcase
            bbuf[k][0] = '{outs: {6'b000000, code}, tag: T_NONE};
            bbuf[k][1] = '{outs: {3'b000, 1'b1, 2'b00, code}, tag: t};
        end else begin
            for (int it = 0; it < nbits[k]; it++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    bbuf[k][2*it+ph].outs = {3'b000, ph[0], (it == nbits[k]-1), 1'b1, 2'b00};
                    bbuf[k][2*it+ph].tag  = (it == nbits[k]-1 && ph == 1) ? T_BOUND : T_NONE;
                end
            end
        end
        cur[k] = bbuf[k][0];
        bi[k]  = 1;
    endtask

    task automatic boundary(input int k, input logic r);
        if (r && !pend[k]) begin
            start_seg(k, 0);
        end else begin
            pend[k] = 1'b0;
            cur[k]  = '{outs: O_HALT, tag: T_HALT};
        end
    endtask

    task automatic advance(input int k, input logic r, input logic d, input logic op2,
                           input logic aop, input logic de, input logic ee, input logic se);
        case (cur[k].tag)
            T_NONE: begin
                cur[k] = bbuf[k][bi[k]];
                bi[k]++;
            end
            T_HALT: begin
                if (de)      cur[k] = '{outs: O_DEP, tag: T_DEP};
                else if (ee) cur[k] = '{outs: O_INC, tag: T_INC};
                else if (se) begin
                    pend[k] = 1'b1;
                    start_seg(k, 0);
                end
                else if (r)  start_seg(k, 0);
                else         cur[k] = '{outs: O_HALT, tag: T_HALT};
            end
            T_DEP:   cur[k] = '{outs: O_INC, tag: T_INC};
            T_INC:   cur[k] = '{outs: O_HALT, tag: T_HALT};
            T_FETCH: start_seg(k, d ? 1 : (!op2 ? 2 : 3));
            T_DEREF: start_seg(k, !op2 ? 2 : 3);
            T_LOAD:  start_seg(k, 3);
            T_EXEC:  if (aop) start_seg(k, 4); else boundary(k, r);
            default: boundary(k, r);
        endcase
    endtask

    // Advance the model on each edge, then compare both DUTs just after it.
    initial begin : monitor
        logic de, ee, se;
        forever begin
            @(posedge clk);
            se = step & ~p_step;
            de = dep_req & ~p_dep;
            ee = exam_req & ~p_exam;
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    cur[k]  = '{outs: O_HALT, tag: T_HALT};
                    pend[k] = 1'b0;
                    bi[k]   = 0;
                end
                p_step = 1'b0; p_dep = 1'b0; p_exam = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                for (int k = 0; k < 2; k++) advance(k, run, deref, o2, alu_op, de, ee, se);
                p_step = step; p_dep = dep_req; p_exam = exam_req;
            end
            #1;
            if (model_valid) begin
                check("model_u4", o4, cur[0].outs);
                check("model_u12", o12, cur[1].outs);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic wait_halted(input string name);
        int n;
        n = 0;
        while (!(o4[5] === 1'b1 && o12[5] === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(o4[5] === 1'b1 && o12[5] === 1'b1), 1);
    endtask

    // ---------------- directed stimulus ----------------
    int pre_ws, alu_ws, alu_cyc;
    logic [7:0] s3_mask, ws_exp, code_exp;

    initial begin : stim
        rst = 1'b1; run = 1'b0; step = 1'b0; dep_req = 1'b0; exam_req = 1'b0;
        deref = 1'b0; o2 = 1'b0; alu_op = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: idle after reset with run low.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_idle_u4", o4, 8'h20);
            check("t1_idle_u12", o12, 8'h20);
        end

        // 2: FETCH/EXEC loop with o2=1.
        run = 1'b1; o2 = 1'b1; deref = 1'b0; alu_op = 1'b0;
        ws_exp   = 8'b1010_1010;
        code_exp = 8'b1100_1100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_ws", 32'(o4[4]), 32'(ws_exp[i]));
            check("t2_code", 32'(o4[1:0]), code_exp[i] ? 32'd3 : 32'd0);
        end

        // 3: FETCH, DEREF, LOAD, EXEC, then an ALU phase of 4 iterations on u4.
        @(negedge clk);
        pre_ws = 0; alu_ws = 0; alu_cyc = 0; s3_mask = '0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0) begin deref = 1'b1; o2 = 1'b0; alu_op = 1'b1; end
            if (j == 8) run = 1'b0;
            if (j < 8) begin
                pre_ws += int'(o4[4]);
            end else begin
                alu_ws  += int'(o4[4]);
                alu_cyc += int'(o4[2]);
                s3_mask[j-8] = o4[3];
            end
            if (j == 2) check("t3_deref_code", 32'(o4[1:0]), 1);
            if (j == 4) check("t3_load_code", 32'(o4[1:0]), 2);
            if (j == 6) check("t3_exec_code", 32'(o4[1:0]), 3);
        end
        check("t3_pre_alu_ws", pre_ws, 4);
        check("t3_alu_ws", alu_ws, 4);
        check("t3_alu_cycles", alu_cyc, 8);
        check("t3_s3_mask", s3_mask, 8'b1100_0000);
        wait_halted("t3_halt");

        // 4: single step; a second edge mid-instruction is ignored.
        deref = 1'b0; o2 = 1'b1; alu_op = 1'b0; step = 1'b1;
        @(negedge clk);
        check("t4_fetch", o4, 8'h00);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        check("t4_exec0", 32'(o4[1:0]), 3);
        @(negedge clk);
        check("t4_exec1_ws", o4, 8'h13);
        @(negedge clk);
        check("t4_halted", 32'(o4[5]), 1);
        @(negedge clk);
        check("t4_still_halted", o4, 8'h20);
        check("t4_still_halted_u12", o12, 8'h20);
        step = 1'b0;

        // 5: deposit with a simultaneous examine, then deposit while running.
        @(negedge clk);
        dep_req = 1'b1; exam_req = 1'b1;
        @(negedge clk);
        check("t5_dep", o4, 8'h40);
        @(negedge clk);
        check("t5_incp", o4, 8'h80);
        @(negedge clk);
        check("t5_halt", o4, 8'h20);
        @(negedge clk);
        check("t5_exam_dropped", o12, 8'h20);
        dep_req = 1'b0; exam_req = 1'b0; run = 1'b1;
        @(negedge clk);
        dep_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_dep_running", 32'(o4[6] | o12[6]), 0);
        end
        run = 1'b0;
        wait_halted("t5_halt_after_run");
        dep_req = 1'b0;

        // 6: reset during ALU iteration 5 of the 12-bit instance.
        deref = 1'b0; o2 = 1'b1; alu_op = 1'b1; run = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_in_alu", 32'({o12[3], o12[2]}), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_u12", o12, 8'h20);
        check("t6_reset_u4", o4, 8'h20);
        rst = 1'b0;
        @(negedge clk);
        check("t6_fetch_u12", o12, 8'h00);
        check("t6_fetch_u4", o4, 8'h00);
        run = 1'b0;
        wait_halted("t6_final_halt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
